bk_bus_arbiter: RTL
===================

# bk_bus_arbiter

Shares the single Q-bus-style system bus of the BK-0010 between the vm1 CPU and one DMA master, using the vm1 DMR/DMGO/SACK handshake. Owns bus-master selection, steers address/data/strobes from the current owner to memory and peripherals, and blocks the non-owner by withholding RPLY. Also provides the bus reply timeout that turns a missing RPLY into a one-cycle bus-error pulse to the current owner. Sits between the vm1 core pins and the system bus decoders.

## Interface
- TIMEOUT, 64, ce cycles a strobe may wait for bus_rply before the error pulse; legal range 2..255

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; returns the block to the reset state immediately
- ce  in  1  clock enable; the FSM and timeout counter advance only on clk edges with ce=1
- cpu_addr  in  16  CPU address (vm1 addr_o)
- cpu_data_o  in  16  CPU write data
- cpu_din, cpu_dout, cpu_wtbt  in  1 each  CPU strobes (vm1 DIN/DOUT/WTBT)
- cpu_rply  out  1  reply to CPU
- cpu_error  out  1  timeout pulse to CPU (feeds vm1 error_i)
- dma_dmr  in  1  DMA request
- dma_dmgo  out  1  DMA grant offer
- dma_sack  in  1  DMA acknowledge / bus held
- dma_addr  in  16  DMA address
- dma_data_o  in  16  DMA write data
- dma_din, dma_dout, dma_wtbt  in  1 each  DMA strobes
- dma_rply  out  1  reply to DMA master
- dma_error  out  1  timeout pulse to DMA master
- bus_addr  out  16  system bus address
- bus_data_o  out  16  system bus write data
- bus_din, bus_dout, bus_wtbt  out  1 each  system bus strobes
- bus_rply  in  1  slave reply
- bus_data_i  in  16  slave read data
- data_i  out  16  read data to both masters (= bus_data_i, combinational)
- owner  out  1  0 = CPU owns bus, 1 = DMA owns bus

## Operation
- States: CPU, OFFER, DMA. Reset state CPU.
- Reset values: owner=0, dma_dmgo=0, cpu_error=0, dma_error=0, timeout counter=0.
- Steering (combinational from owner register): owner=0: bus_* = cpu_*, cpu_rply=bus_rply, dma_rply=0. owner=1: bus_* = dma_*, dma_rply=bus_rply, cpu_rply=0. Non-owner strobes never reach the bus.
- CPU: go OFFER when dma_dmr=1 and cpu_din=0 and cpu_dout=0 (CPU between cycles). In-progress CPU cycle always completes first; simultaneous dma_dmr rise and cpu_din/cpu_dout rise -> CPU wins, offer deferred.
- OFFER: dma_dmgo=1, owner still 0 but CPU strobes are masked off the bus (bus strobes 0, cpu_rply=0), so CPU cannot start a cycle. dma_sack=1 -> DMA. dma_dmr=0 and dma_sack=0 -> CPU (request withdrawn).
- DMA: owner=1, dma_dmgo=0. Leave to CPU when dma_sack=0 and dma_din=0 and dma_dout=0; dma_sack dropping with a DMA strobe still high -> stay in DMA until strobes clear.
- CPU strobes raised during OFFER/DMA simply stall (no reply) and proceed once owner returns to CPU.
- dma_sack without prior dma_dmgo (state CPU) ignored.
- Timeout counter, 8 bits: increments on ce when (bus_din|bus_dout)=1 and bus_rply=0; clears when strobes low or bus_rply=1; saturates at TIMEOUT. On the ce edge where it reaches TIMEOUT, owner's error output (cpu_error if owner=0, else dma_error) goes high for exactly one clk cycle. No repeat pulse until strobes drop and a new cycle times out.
- Ownership change clears the counter.
- reset asserted mid-DMA: owner=0, dma_dmgo=0 at once, regardless of dma_sack.

## Timing
- dma_dmgo rises on the first ce edge where CPU-state condition holds (1 ce cycle latency).
- owner becomes 1 on the ce edge sampling dma_sack=1 in OFFER; dma_dmgo falls on the same edge.
- owner returns to 0 on the ce edge sampling release condition in DMA.
- Steering, rply routing and data_i have zero-cycle combinational latency.
- Error pulse: registered, one clk wide, TIMEOUT ce cycles after strobe onset without reply.

## Test plan
- CPU read, bus_rply after 3 ce cycles, dma idle -> bus mirrors cpu_*, cpu_rply follows bus_rply, owner=0, no error.
- dma_dmr during CPU DIN -> dma_dmgo stays 0 until cpu_din falls, then rises 1 ce cycle later; dma_sack=1 -> owner=1 next ce edge, dmgo=0; DMA write addr 0o40000 appears on bus_addr, dma_rply=bus_rply, cpu_rply=0.
- CPU raises DIN while owner=1 -> bus_din follows dma_din only, cpu_rply=0; after dma_sack=0 with strobes low, owner=0 and CPU cycle completes.
- OFFER, dma_dmr dropped without sack -> back to CPU, dmgo=0, owner never 1.
- CPU DIN to unmapped address, bus_rply never, TIMEOUT=64 -> cpu_error one clk pulse after 64 ce cycles, no second pulse while DIN held; same with DMA owner -> dma_error only.
- reset pulsed while owner=1 and dma_sack=1 -> owner=0, dma_dmgo=0, errors 0 immediately, without clock edge.

Source files
------------

// File: rtl/bk_bus_arbiter.sv
// BK-0010 system bus arbiter: shares the bus between the vm1 CPU and one DMA master
// via the DMR/DMGO/SACK handshake, and converts a missing RPLY into a one-clock error pulse.
module bk_bus_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_data_o,
  input  logic        cpu_din,
  input  logic        cpu_dout,
  input  logic        cpu_wtbt,
  output logic        cpu_rply,
  output logic        cpu_error,
  input  logic        dma_dmr,
  output logic        dma_dmgo,
  input  logic        dma_sack,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_data_o,
  input  logic        dma_din,
  input  logic        dma_dout,
  input  logic        dma_wtbt,
  output logic        dma_rply,
  output logic        dma_error,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_data_o,
  output logic        bus_din,
  output logic        bus_dout,
  output logic        bus_wtbt,
  input  logic        bus_rply,
  input  logic [15:0] bus_data_i,
  output logic [15:0] data_i,
  output logic        owner
);

  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_OFFER = 2'd1,
    ST_DMA   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       dmgo_q, dmgo_d;
  logic       cpu_err_q, cpu_err_d;
  logic       dma_err_q, dma_err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cpu_mask_s;
  logic       strobe_s;

  // Steer the owner's address, data and strobes onto the bus; reply goes only to the owner.
  always_comb begin
    cpu_mask_s = (state_q == ST_OFFER);
    if (owner_q) begin
      bus_addr   = dma_addr;
      bus_data_o = dma_data_o;
      bus_din    = dma_din;
      bus_dout   = dma_dout;
      bus_wtbt   = dma_wtbt;
      dma_rply   = bus_rply;
      cpu_rply   = 1'b0;
    end else begin
      // While the grant is offered the CPU is kept off the bus so it cannot start a cycle.
      bus_addr   = cpu_addr;
      bus_data_o = cpu_data_o;
      bus_din    = cpu_din  & ~cpu_mask_s;
      bus_dout   = cpu_dout & ~cpu_mask_s;
      bus_wtbt   = cpu_wtbt & ~cpu_mask_s;
      cpu_rply   = bus_rply & ~cpu_mask_s;
      dma_rply   = 1'b0;
    end
  end

  assign data_i    = bus_data_i;
  assign owner     = owner_q;
  assign dma_dmgo  = dmgo_q;
  assign cpu_error = cpu_err_q;
  assign dma_error = dma_err_q;

  // Bus-master handshake: CPU -> OFFER -> DMA -> CPU, advancing only on ce.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dmgo_d  = dmgo_q;
    if (ce) begin
      case (state_q)
        ST_CPU: begin
          if (dma_dmr && !cpu_din && !cpu_dout) begin
            state_d = ST_OFFER;
            dmgo_d  = 1'b1;
          end else begin
            state_d = ST_CPU;
          end
        end
        ST_OFFER: begin
          if (dma_sack) begin
            state_d = ST_DMA;
            owner_d = 1'b1;
            dmgo_d  = 1'b0;
          end else if (!dma_dmr) begin
            state_d = ST_CPU;
            dmgo_d  = 1'b0;
          end else begin
            state_d = ST_OFFER;
          end
        end
        ST_DMA: begin
          // A DMA cycle still in flight keeps the bus even after SACK drops.
          if (!dma_sack && !dma_din && !dma_dout) begin
            state_d = ST_CPU;
            owner_d = 1'b0;
          end else begin
            state_d = ST_DMA;
          end
        end
        default: begin
          state_d = ST_CPU;
          owner_d = 1'b0;
          dmgo_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Reply timeout: count unanswered strobe cycles, fire once when the limit is reached.
  always_comb begin
    strobe_s  = bus_din | bus_dout;
    cnt_d     = cnt_q;
    cpu_err_d = 1'b0;
    dma_err_d = 1'b0;
    if (!ce) begin
      cnt_d = cnt_q;
    end else if (owner_d != owner_q) begin
      cnt_d = 8'd0;
    end else if (!strobe_s || bus_rply) begin
      cnt_d = 8'd0;
    end else if (cnt_q < TIMEOUT_C) begin
      cnt_d     = cnt_q + 8'd1;
      cpu_err_d = (cnt_q == TIMEOUT_M1) & ~owner_q;
      dma_err_d = (cnt_q == TIMEOUT_M1) &  owner_q;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, grant, owner, counter and error-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CPU;
      owner_q   <= 1'b0;
      dmgo_q    <= 1'b0;
      cnt_q     <= 8'd0;
      cpu_err_q <= 1'b0;
      dma_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      dmgo_q    <= dmgo_d;
      cnt_q     <= cnt_d;
      cpu_err_q <= cpu_err_d;
      dma_err_q <= dma_err_d;
    end
  end

endmodule
